// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-RAM arbiter: status/rw codes, FSM states, widths.
package mem_arbiter_pkg;

    localparam int AddrLen = 32;
    localparam int RegLen  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } status_e;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    function automatic logic qtyValid(input logic [2:0] qty);
        return (qty >= 3'd1) && (qty <= 3'd4);
    endfunction

endpackage

// File: rtl/mem_arbiter_beat_seq.sv
// Byte sequencer: beat counter, base+k address generation, little-endian byte shift in/out.
import mem_arbiter_pkg::*;

module mem_arbiter_beat_seq #(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = RegLen
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_startRead,
    input  logic [ADDR_W-1:0] i_startAddr,
    input  logic [2:0]        i_startQty,
    input  logic [DATA_W-1:0] i_startWdata,
    input  logic              i_readBeat,
    input  logic              i_writeBeat,
    input  logic [7:0]        i_ramDin,
    output logic [2:0]        o_cnt,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wbyte,
    output logic [DATA_W-1:0] o_data,
    output logic              o_readLast,
    output logic              o_writeLast
);

    logic [2:0]        r_cnt;
    logic [2:0]        r_qty;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_buf;
    logic [1:0]        w_capIdx;

    // A read beat at count k captures the byte addressed one cycle earlier (k-1).
    assign w_capIdx = 2'(r_cnt - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_qty  <= '0;
            r_base <= '0;
            r_buf  <= '0;
        end else if (i_start) begin
            r_base <= i_startAddr;
            r_qty  <= i_startQty;
            r_cnt  <= i_startRead ? 3'd1 : 3'd0;
            r_buf  <= i_startRead ? '0 : i_startWdata;
        end else if (i_readBeat) begin
            r_buf[{w_capIdx, 3'b000} +: 8] <= i_ramDin;
            r_cnt <= r_cnt + 3'd1;
        end else if (i_writeBeat) begin
            r_buf <= {8'h00, r_buf[DATA_W-1:8]};
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_addr      = r_base + ADDR_W'(r_cnt);
    assign o_wbyte     = r_buf[7:0];
    assign o_data      = r_buf;
    assign o_readLast  = (r_cnt == r_qty);
    assign o_writeLast = (r_cnt == r_qty - 3'd1);

endmodule

// File: rtl/mem_arbiter.sv
// Grant/status FSM owning the byte-wide RAM port for IF fetches and MEM loads/stores.
// Define MEMARB_IF_PREEMPT_EN to let a MEM request abort an early-stage IF fetch.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = RegLen
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic [1:0]        o_if_status,
    input  logic [2:0]        i_mem_rw,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    input  logic [3:0]        i_mem_quantity,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic [1:0]        o_mem_status,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_wr,
    output logic [7:0]        o_ram_dout,
    input  logic [7:0]        i_ram_din
);

    state_e            r_state;
    state_e            w_next;
    logic              r_ownerIf;
    logic              r_isRead;
    logic              w_memRead;
    logic              w_memWrite;
    logic              w_memValid;
    logic              w_idle;
    logic              w_grantMem;
    logic              w_grantIf;
    logic              w_start;
    logic              w_startRead;
    logic [ADDR_W-1:0] w_startAddr;
    logic [2:0]        w_startQty;
    logic              w_readBeat;
    logic              w_writeBeat;
    logic [2:0]        w_seqCnt;
    logic [ADDR_W-1:0] w_seqAddr;
    logic [7:0]        w_seqByte;
    logic [DATA_W-1:0] w_seqData;
    logic              w_readLast;
    logic              w_writeLast;
    logic              w_unusedQtyMsb;

    assign w_unusedQtyMsb = i_mem_quantity[3];

    assign w_memRead   = (i_mem_rw == {1'b0, RW_READ});
    assign w_memWrite  = (i_mem_rw == {1'b0, RW_WRITE});
    assign w_memValid  = (w_memRead || w_memWrite) && qtyValid(i_mem_quantity[2:0]);

    // Gating with rst_n keeps the combinational grant-cycle address at 0 during reset.
    assign w_idle      = (r_state == S_IDLE) && rst_n;
    assign w_grantMem  = w_idle && w_memValid;
    assign w_grantIf   = w_idle && !w_memValid && i_if_req;
    assign w_start     = w_grantMem || w_grantIf;
    assign w_startRead = w_grantIf || w_memRead;
    assign w_startAddr = w_grantMem ? i_mem_addr : i_if_addr;
    assign w_startQty  = w_grantMem ? i_mem_quantity[2:0] : 3'd4;
    assign w_readBeat  = (r_state == S_READ);
    assign w_writeBeat = (r_state == S_WRITE);

    mem_arbiter_beat_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_beat_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_start),
        .i_startRead  (w_startRead),
        .i_startAddr  (w_startAddr),
        .i_startQty   (w_startQty),
        .i_startWdata (i_mem_wdata),
        .i_readBeat   (w_readBeat),
        .i_writeBeat  (w_writeBeat),
        .i_ramDin     (i_ram_din),
        .o_cnt        (w_seqCnt),
        .o_addr       (w_seqAddr),
        .o_wbyte      (w_seqByte),
        .o_data       (w_seqData),
        .o_readLast   (w_readLast),
        .o_writeLast  (w_writeLast)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ownerIf <= 1'b0;
            r_isRead  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_ownerIf <= w_grantIf;
                r_isRead  <= w_startRead;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grantMem) begin
                    w_next = w_memRead ? S_READ : S_WRITE;
                end else if (w_grantIf) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (r_ownerIf && !i_if_req) begin
                    w_next = S_IDLE;
`ifdef MEMARB_IF_PREEMPT_EN
                end else if (r_ownerIf && w_memValid && (w_seqCnt < 3'd3)) begin
                    w_next = S_IDLE;
`endif
                end else if (w_readLast) begin
                    w_next = S_DONE;
                end
            end
            S_WRITE: begin
                if (w_writeLast) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_ram_addr   = '0;
        o_ram_wr     = 1'b0;
        o_ram_dout   = '0;
        o_if_status  = IDLE;
        o_mem_status = IDLE;
        o_if_rdata   = '0;
        o_mem_rdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start && w_startRead) begin
                    o_ram_addr = w_startAddr;
                end
            end
            S_READ: begin
                if (!w_readLast) begin
                    o_ram_addr = w_seqAddr;
                end
                if (r_ownerIf) begin
                    o_if_status = BUSY;
                end else begin
                    o_mem_status = BUSY;
                end
            end
            S_WRITE: begin
                o_ram_addr   = w_seqAddr;
                o_ram_wr     = 1'b1;
                o_ram_dout   = w_seqByte;
                o_mem_status = BUSY;
            end
            S_DONE: begin
                if (r_ownerIf) begin
                    o_if_status = DONE;
                    o_if_rdata  = w_seqData;
                end else begin
                    o_mem_status = DONE;
                    o_mem_rdata  = r_isRead ? w_seqData : '0;
                end
            end
            default: begin
                o_ram_addr = '0;
            end
        endcase
    end

endmodule
